// File: rtl/dice_display_scheduler.sv
// dice_display_scheduler
// Time-multiplexes the shared segment bus of the two-digit dice display.
// Each frame runs BLANK_A -> SHOW_1 -> BLANK_B -> SHOW_10. All display inputs
// are captured once per frame, on the first BLANK_A cycle, so a frame never
// tears. Every output is registered from the next-state/next-snapshot view,
// so pins change on the edge that enters a state and hold for the whole state.
module dice_display_scheduler #(
  parameter int SLOT_CYCLES  = 2000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit1,
  input  logic [3:0] digit10,
  input  logic       lz_blank,
  input  logic       ovr_en,
  input  logic [7:0] ovr_seg1,
  input  logic [7:0] ovr_seg10,
  input  logic       seg_pol,
  input  logic       com_pol,
  output logic [7:0] seg,
  output logic       com1,
  output logic       com10,
  output logic [1:0] com_oe,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    BLANK_A = 2'd0,
    SHOW_1  = 2'd1,
    BLANK_B = 2'd2,
    SHOW_10 = 2'd3
  } state_t;

  // Seven-segment decode (bit0 = a ... bit6 = g); dp never lit, 10-15 blank.
  function automatic logic [7:0] decode_digit(input logic [3:0] d);
    logic [7:0] pat;
    case (d)
      4'd0:    pat = 8'h3F;
      4'd1:    pat = 8'h06;
      4'd2:    pat = 8'h5B;
      4'd3:    pat = 8'h4F;
      4'd4:    pat = 8'h66;
      4'd5:    pat = 8'h6D;
      4'd6:    pat = 8'h7D;
      4'd7:    pat = 8'h07;
      4'd8:    pat = 8'h7F;
      4'd9:    pat = 8'h6F;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  // Sequencer state
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             run_r;
  logic             snap_take_s;

  // Frame snapshot registers
  logic [3:0] snap_digit1_r;
  logic [3:0] snap_digit10_r;
  logic       snap_lz_blank_r;
  logic       snap_ovr_en_r;
  logic [7:0] snap_ovr_seg1_r;
  logic [7:0] snap_ovr_seg10_r;
  logic       snap_seg_pol_r;
  logic       snap_com_pol_r;

  // Snapshot as seen by the cycle being entered
  logic [3:0] eff_digit1_s;
  logic [3:0] eff_digit10_s;
  logic       eff_lz_blank_s;
  logic       eff_ovr_en_s;
  logic [7:0] eff_ovr_seg1_s;
  logic [7:0] eff_ovr_seg10_s;
  logic       eff_seg_pol_s;
  logic       eff_com_pol_s;

  // Lit patterns and pin values for the next cycle
  logic [7:0] lit1_s;
  logic [7:0] lit10_s;
  logic [7:0] lit_s;
  logic       act1_s;
  logic       act10_s;
  logic [7:0] seg_s;
  logic       com1_s;
  logic       com10_s;

  // Next-state logic: a fresh BLANK_A after reset, then fixed-length states in a ring.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (!run_r) begin
      state_s = BLANK_A;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        BLANK_A: begin
          if (cnt_r == BLANK_LAST) begin
            state_s = SHOW_1;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = BLANK_A;
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        SHOW_1: begin
          if (cnt_r == SLOT_LAST) begin
            state_s = BLANK_B;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = SHOW_1;
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        BLANK_B: begin
          if (cnt_r == BLANK_LAST) begin
            state_s = SHOW_10;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = BLANK_B;
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        SHOW_10: begin
          if (cnt_r == SLOT_LAST) begin
            state_s = BLANK_A;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = SHOW_10;
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = BLANK_A;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // The snapshot is taken on the edge that enters the first BLANK_A cycle.
  always_comb begin
    snap_take_s = 1'b0;
    if ((state_s == BLANK_A) && (cnt_s == CNT_ZERO)) begin
      snap_take_s = 1'b1;
    end else begin
      snap_take_s = 1'b0;
    end
  end

  // State register; reset parks the sequencer until the first released edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BLANK_A;
      cnt_r   <= CNT_ZERO;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      run_r   <= 1'b1;
    end
  end

  // Capture all display inputs once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_digit1_r    <= 4'd0;
      snap_digit10_r   <= 4'd0;
      snap_lz_blank_r  <= 1'b0;
      snap_ovr_en_r    <= 1'b0;
      snap_ovr_seg1_r  <= 8'h00;
      snap_ovr_seg10_r <= 8'h00;
      snap_seg_pol_r   <= 1'b0;
      snap_com_pol_r   <= 1'b0;
    end else if (snap_take_s) begin
      snap_digit1_r    <= digit1;
      snap_digit10_r   <= digit10;
      snap_lz_blank_r  <= lz_blank;
      snap_ovr_en_r    <= ovr_en;
      snap_ovr_seg1_r  <= ovr_seg1;
      snap_ovr_seg10_r <= ovr_seg10;
      snap_seg_pol_r   <= seg_pol;
      snap_com_pol_r   <= com_pol;
    end else begin
      snap_digit1_r    <= snap_digit1_r;
      snap_digit10_r   <= snap_digit10_r;
      snap_lz_blank_r  <= snap_lz_blank_r;
      snap_ovr_en_r    <= snap_ovr_en_r;
      snap_ovr_seg1_r  <= snap_ovr_seg1_r;
      snap_ovr_seg10_r <= snap_ovr_seg10_r;
      snap_seg_pol_r   <= snap_seg_pol_r;
      snap_com_pol_r   <= snap_com_pol_r;
    end
  end

  // On the snapshot edge the outputs must already reflect the new inputs.
  always_comb begin
    eff_digit1_s    = snap_digit1_r;
    eff_digit10_s   = snap_digit10_r;
    eff_lz_blank_s  = snap_lz_blank_r;
    eff_ovr_en_s    = snap_ovr_en_r;
    eff_ovr_seg1_s  = snap_ovr_seg1_r;
    eff_ovr_seg10_s = snap_ovr_seg10_r;
    eff_seg_pol_s   = snap_seg_pol_r;
    eff_com_pol_s   = snap_com_pol_r;
    if (snap_take_s) begin
      eff_digit1_s    = digit1;
      eff_digit10_s   = digit10;
      eff_lz_blank_s  = lz_blank;
      eff_ovr_en_s    = ovr_en;
      eff_ovr_seg1_s  = ovr_seg1;
      eff_ovr_seg10_s = ovr_seg10;
      eff_seg_pol_s   = seg_pol;
      eff_com_pol_s   = com_pol;
    end else begin
      eff_digit1_s    = snap_digit1_r;
      eff_digit10_s   = snap_digit10_r;
    end
  end

  // Per-slot lit patterns: override verbatim, else decode with leading-zero blanking.
  always_comb begin
    lit1_s  = 8'h00;
    lit10_s = 8'h00;
    if (eff_ovr_en_s) begin
      lit1_s  = eff_ovr_seg1_s;
      lit10_s = eff_ovr_seg10_s;
    end else if (eff_lz_blank_s && (eff_digit10_s == 4'd0)) begin
      lit1_s  = decode_digit(eff_digit1_s);
      lit10_s = 8'h00;
    end else begin
      lit1_s  = decode_digit(eff_digit1_s);
      lit10_s = decode_digit(eff_digit10_s);
    end
  end

  // Choose what the entered state shows; only one common can ever be active.
  always_comb begin
    lit_s   = 8'h00;
    act1_s  = 1'b0;
    act10_s = 1'b0;
    case (state_s)
      SHOW_1: begin
        lit_s  = lit1_s;
        act1_s = 1'b1;
      end
      SHOW_10: begin
        lit_s   = lit10_s;
        act10_s = 1'b1;
      end
      BLANK_A, BLANK_B: begin
        lit_s = 8'h00;
      end
      default: begin
        lit_s = 8'h00;
      end
    endcase
  end

  // Apply the board's segment and common polarities.
  always_comb begin
    seg_s   = 8'h00;
    com1_s  = 1'b0;
    com10_s = 1'b0;
    if (eff_seg_pol_s) begin
      seg_s = lit_s;
    end else begin
      seg_s = ~lit_s;
    end
    if (act1_s) begin
      com1_s = eff_com_pol_s;
    end else begin
      com1_s = ~eff_com_pol_s;
    end
    if (act10_s) begin
      com10_s = eff_com_pol_s;
    end else begin
      com10_s = ~eff_com_pol_s;
    end
  end

  // Output registers; reset forces every pin low and releases the commons.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= 8'h00;
      com1       <= 1'b0;
      com10      <= 1'b0;
      com_oe     <= 2'b00;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_s;
      com1       <= com1_s;
      com10      <= com10_s;
      com_oe     <= 2'b11;
      frame_tick <= snap_take_s;
    end
  end

endmodule

// File: tb/tb_dice_display_scheduler.sv
// Self-checking bench for dice_display_scheduler.
// A frame-position model (cycles since release, modulo the frame length)
// predicts every output each cycle; directed checks pin known values.
module tb_dice_display_scheduler;

  localparam int SLOT  = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 2 * (SLOT + BLANK);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       lz_blank;
  logic       ovr_en;
  logic [7:0] ovr_seg1;
  logic [7:0] ovr_seg10;
  logic       seg_pol;
  logic       com_pol;
  logic [7:0] seg;
  logic       com1;
  logic       com10;
  logic [1:0] com_oe;
  logic       frame_tick;

  always #5 clk = ~clk;

  dice_display_scheduler #(
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit1    (digit1),
    .digit10   (digit10),
    .lz_blank  (lz_blank),
    .ovr_en    (ovr_en),
    .ovr_seg1  (ovr_seg1),
    .ovr_seg10 (ovr_seg10),
    .seg_pol   (seg_pol),
    .com_pol   (com_pol),
    .seg       (seg),
    .com1      (com1),
    .com10     (com10),
    .com_oe    (com_oe),
    .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] digit_pattern(input logic [3:0] d);
    logic [7:0] tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    if (d < 4'd10) return tab[d];
    return 8'h00;
  endfunction

  // ---------------- reference model ----------------
  bit         m_valid = 1'b0;
  bit         m_run   = 1'b0;
  int         m_t     = 0;
  int         m_slot  = 0;
  logic [3:0] s_d1, s_d10;
  logic       s_lz, s_ovr, s_sp, s_cp;
  logic [7:0] s_o1, s_o10;
  logic [7:0] m_lit;
  logic [7:0] e_seg;
  logic       e_c1, e_c10, e_tick;
  logic [1:0] e_oe;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      e_seg   = 8'h00;
      e_c1    = 1'b0;
      e_c10   = 1'b0;
      e_oe    = 2'b00;
      e_tick  = 1'b0;
    end else if (m_valid) begin
      if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (m_t == 0) begin
        s_d1 = digit1;  s_d10 = digit10; s_lz = lz_blank; s_ovr = ovr_en;
        s_o1 = ovr_seg1; s_o10 = ovr_seg10; s_sp = seg_pol; s_cp = com_pol;
      end
      if (m_t < BLANK)                  m_slot = 0;
      else if (m_t < BLANK + SLOT)      m_slot = 1;
      else if (m_t < 2 * BLANK + SLOT)  m_slot = 0;
      else                              m_slot = 2;
      if (m_slot == 1)
        m_lit = s_ovr ? s_o1 : digit_pattern(s_d1);
      else if (m_slot == 2)
        m_lit = s_ovr ? s_o10 : ((s_lz && s_d10 == 4'd0) ? 8'h00 : digit_pattern(s_d10));
      else
        m_lit = 8'h00;
      e_seg  = s_sp ? m_lit : ~m_lit;
      e_c1   = (m_slot == 1) ? s_cp : ~s_cp;
      e_c10  = (m_slot == 2) ? s_cp : ~s_cp;
      e_oe   = 2'b11;
      e_tick = (m_t == 0);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_seg",   32'(seg),        32'(e_seg));
      check("model_com1",  32'(com1),       32'(e_c1));
      check("model_com10", 32'(com10),      32'(e_c10));
      check("model_oe",    32'(com_oe),     32'(e_oe));
      check("model_tick",  32'(frame_tick), 32'(e_tick));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      @(negedge clk);
      got = (frame_tick === 1'b1);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick: no frame_tick within %0d cycles at %0t", 3 * FRAME, $time);
    end
  endtask

  initial begin
    rst = 1'b1; digit1 = 4'd2; digit10 = 4'd4; lz_blank = 1'b0; ovr_en = 1'b0;
    ovr_seg1 = 8'h00; ovr_seg10 = 8'h00; seg_pol = 1'b1; com_pol = 1'b1;
    step(3);
    check("rst_seg",  32'(seg),    32'h00);
    check("rst_oe",   32'(com_oe), 32'h0);
    check("rst_com1", 32'(com1),   32'h0);
    rst = 1'b0;

    // Basic cycle: 1 blank, 4x ones (5B), 1 blank, 4x tens (66)
    step(1);
    check("basic_tick0", 32'(frame_tick), 32'h1);
    check("basic_oe",    32'(com_oe),     32'h3);
    check("basic_blank", 32'(seg),        32'h00);
    step(1);
    check("basic_ones_seg", 32'(seg),  32'h5B);
    check("basic_ones_com", 32'(com1), 32'h1);
    step(4);
    check("basic_blankb_seg",  32'(seg),        32'h00);
    check("basic_blankb_tick", 32'(frame_tick), 32'h0);
    step(1);
    check("basic_tens_seg", 32'(seg),   32'h66);
    check("basic_tens_com", 32'(com10), 32'h1);
    step(4);
    check("basic_period", 32'(frame_tick), 32'h1);

    // Inverted polarity
    seg_pol = 1'b0; com_pol = 1'b0; digit1 = 4'd8;
    wait_tick();
    check("inv_blank_seg", 32'(seg),   32'hFF);
    check("inv_blank_c1",  32'(com1),  32'h1);
    check("inv_blank_c10", 32'(com10), 32'h1);
    step(1);
    check("inv_ones_seg", 32'(seg),   32'h80);
    check("inv_ones_c1",  32'(com1),  32'h0);
    check("inv_ones_c10", 32'(com10), 32'h1);

    // Leading-zero suppression
    seg_pol = 1'b1; com_pol = 1'b1; digit10 = 4'd0; digit1 = 4'd7; lz_blank = 1'b1;
    wait_tick();
    step(6);
    check("lz_on_seg", 32'(seg),   32'h00);
    check("lz_on_com", 32'(com10), 32'h1);
    lz_blank = 1'b0;
    wait_tick();
    step(6);
    check("lz_off_seg", 32'(seg), 32'h3F);

    // Snapshot integrity
    digit1 = 4'd3;
    wait_tick();
    step(2);
    check("snap_before", 32'(seg), 32'h4F);
    digit1 = 4'd9;
    step(1);
    check("snap_hold", 32'(seg), 32'h4F);
    wait_tick();
    step(1);
    check("snap_next", 32'(seg), 32'h6F);

    // Override
    ovr_en = 1'b1; ovr_seg1 = 8'h80; ovr_seg10 = 8'h49; digit1 = 4'd12;
    wait_tick();
    step(1);
    check("ovr_ones", 32'(seg), 32'h80);
    step(5);
    check("ovr_tens", 32'(seg), 32'h49);
    ovr_en = 1'b0;
    wait_tick();
    step(1);
    check("d12_ones_seg", 32'(seg),  32'h00);
    check("d12_ones_com", 32'(com1), 32'h1);

    // Mid-frame reset during SHOW_10
    wait_tick();
    step(7);
    check("mid_pre_c10", 32'(com10), 32'h1);
    rst = 1'b1;
    step(1);
    check("mid_rst_seg", 32'(seg),    32'h00);
    check("mid_rst_c10", 32'(com10),  32'h0);
    check("mid_rst_oe",  32'(com_oe), 32'h0);
    rst = 1'b0;
    step(1);
    check("mid_rel_tick", 32'(frame_tick), 32'h1);
    check("mid_rel_oe",   32'(com_oe),     32'h3);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        digit1    = 4'($urandom_range(0, 15));
        digit10   = 4'($urandom_range(0, 15));
        lz_blank  = 1'($urandom_range(0, 1));
        ovr_en    = 1'($urandom_range(0, 1));
        ovr_seg1  = 8'($urandom_range(0, 255));
        ovr_seg10 = 8'($urandom_range(0, 255));
        seg_pol   = 1'($urandom_range(0, 1));
        com_pol   = 1'($urandom_range(0, 1));
      end
    end
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dice_display_scheduler.md
# dice_display_scheduler

Time-multiplexing controller for the two-digit 7-segment display of the dice roller. It alternates the shared segment bus between the ones digit and the tens digit, with blanking dead-time between slots. It selects per frame between the dice result and a raw-segment override written over I2C, and applies the board's configured segment and common polarities. It sits between the roll engine / I2C register file and the `uo_out` and `uio_out[1:0]` pins.

## Interface
- `SLOT_CYCLES`, default 2000: clock cycles each digit is lit; legal range ≥1.
- `BLANK_CYCLES`, default 50: dead-time cycles before each slot, all digits off; legal range ≥1.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `digit1` input, 4 bits: ones digit of the roll result; 0–9 valid, 10–15 shown blank.
- `digit10` input, 4 bits: tens digit; same encoding as `digit1`.
- `lz_blank` input, 1 bit: 1 = suppress a leading zero on the tens digit.
- `ovr_en` input, 1 bit: 1 = show the override segment patterns instead of the digits.
- `ovr_seg1` input, 8 bits: lit-pattern for the ones slot (bit0 = a … bit6 = g, bit7 = dp).
- `ovr_seg10` input, 8 bits: lit-pattern for the tens slot.
- `seg_pol` input, 1 bit: segment polarity (`uio_in[6]`); 1 = segment lit when pin high.
- `com_pol` input, 1 bit: common polarity (`uio_in[7]`); 1 = digit active when pin high.
- `seg` output, 8 bits: segment pins (`uo_out`).
- `com1` output, 1 bit: ones-digit common (`uio_out[0]`).
- `com10` output, 1 bit: tens-digit common (`uio_out[1]`).
- `com_oe` output, 2 bits: output enables for `com10` and `com1` (`uio_oe[1:0]`).
- `frame_tick` output, 1 bit: one-cycle pulse marking the snapshot cycle.

## Operation
- FSM states: BLANK_A → SHOW_1 → BLANK_B → SHOW_10 → BLANK_A.
  - BLANK_A and BLANK_B last `BLANK_CYCLES` cycles each.
  - SHOW_1 and SHOW_10 last `SLOT_CYCLES` cycles each.
  - Frame length is 2·(`BLANK_CYCLES` + `SLOT_CYCLES`) cycles.
- Snapshot: on the first cycle of BLANK_A, register `digit1`, `digit10`, `lz_blank`, `ovr_en`, `ovr_seg1`, `ovr_seg10`, `seg_pol` and `com_pol`.
  - `frame_tick` = 1 on that cycle only.
  - All display output in the frame uses the snapshot, so a frame never tears.
- Lit pattern per slot when `ovr_en` = 0, decoded from the digit:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10–15 decode to 00.
  - dp is always 0.
- Lit pattern when `ovr_en` = 1: `ovr_seg1` / `ovr_seg10` pass through verbatim, including dp.
- Leading-zero suppression: if `lz_blank`=1, `ovr_en`=0 and `digit10`=0, the tens pattern is 00. Tens common is still driven active in SHOW_10.
- Pin mapping:
  - `seg` = `seg_pol` ? lit : ~lit.
  - Active common = `com_pol`; inactive common = ~`com_pol`.
- Blank states: lit = 00, both commons inactive.
- SHOW_1: `com1` active, `com10` inactive. SHOW_10: the reverse. Both commons are never active in the same cycle.
- `com_oe` = 2'b11 from the first cycle after reset onward.

## Timing
- Reset (`rst`=1 at an edge), next cycle values:
  - `seg`=8'h00, `com1`=0, `com10`=0, `com_oe`=2'b00, `frame_tick`=0.
  - FSM in BLANK_A with cycle counter 0.
  - Snapshot registers zeroed.
- First cycle after `rst` falls: BLANK_A cycle 0, so `frame_tick`=1 and the snapshot is taken that cycle.
- Outputs are registered from next-state logic. They change on the same edge that enters a state and hold stable for the whole state; no glitches.
- First SHOW_1 output appears `BLANK_CYCLES` cycles after the snapshot. Input changes appear at the next frame boundary, within at most one frame plus `BLANK_CYCLES`.
- Reset mid-frame: immediate return to the reset values above. The frame is abandoned, with no completion of the current slot.
- Polarity inputs change mid-frame: ignored until the next snapshot.
- Counter width: ceil(log2(max(`SLOT_CYCLES`, `BLANK_CYCLES`))) bits. It wraps to 0 on every state transition and never overflows.

## Test plan
- Reset and basic cycle (`SLOT_CYCLES`=4, `BLANK_CYCLES`=1, `seg_pol`=`com_pol`=1, `digit10`=4, `digit1`=2):
  - During `rst`, all outputs are 0.
  - After release: 1 blank cycle, then 4 cycles `com1`=1 with `seg`=5B, 1 blank cycle, then 4 cycles `com10`=1 with `seg`=66.
  - Period is 10 cycles; `frame_tick` asserts every 10th cycle.
- Inverted polarity (`seg_pol`=`com_pol`=0, `digit1`=8): ones slot shows `seg`=80 with `com1`=0; blank states show `seg`=FF with both commons at 1.
- Leading zero (`digit10`=0, `digit1`=7):
  - With `lz_blank`=1: tens slot `seg`=00 with `com10` active.
  - With `lz_blank`=0: tens slot `seg`=3F.
- Snapshot integrity: change `digit1` 3→9 in the middle of SHOW_1. The slot keeps showing 4F; the next frame shows 6F in its ones slot.
- Override: `ovr_en`=1, `ovr_seg1`=80, `ovr_seg10`=49, `digit1`=12 → ones slot `seg`=80, tens slot `seg`=49. With `ovr_en`=0, `digit1`=12 → ones slot `seg`=00.
- Mid-frame reset: assert `rst` for 1 cycle during SHOW_10. Outputs go to 0 and `com_oe`=00 the next cycle; after release, a fresh BLANK_A with `frame_tick`=1 begins; both commons are never active together.
